// File: rtl/cle_chk_pkg.sv
// Shared constants, FSM state encoding and map-entry type for the CLE label checker.
package cle_chk_pkg;

    localparam int IMG_W   = 32;
    localparam int IMG_H   = 32;
    localparam int LBL_W   = 8;
    localparam int MAX_OBJ = 32;
    localparam int N       = IMG_W * IMG_H;
    localparam int ADDR_W  = $clog2(N);
    localparam int OBJ_W   = $clog2(MAX_OBJ + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } chk_state_t;

    typedef struct packed {
        logic             valid;
        logic [LBL_W-1:0] label;
    } map_entry_t;

    // Index width of the object table; a single-entry table still needs one bit.
    function automatic int map_idx_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/cle_label_map.sv
// Golden-object -> DUT-label binding table: indexed read, CAM over bound labels,
// one bind write per cycle and a synchronous clear of every valid bit.
module cle_label_map #(
    parameter int LBL_W   = 8,
    parameter int MAX_OBJ = 32,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [LBL_W-1:0] rd_label,
    input  logic [LBL_W-1:0] cam_label,
    output logic             cam_hit,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [LBL_W-1:0] wr_label
);

    typedef struct packed {
        logic             valid;
        logic [LBL_W-1:0] label;
    } entry_t;

    entry_t map_q [MAX_OBJ];
    entry_t map_d [MAX_OBJ];

    // Next table contents: clear-all wins over a bind write.
    always_comb begin
        map_d = map_q;
        if (clr) begin
            for (int i = 0; i < MAX_OBJ; i++) begin
                map_d[i].valid = 1'b0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < MAX_OBJ; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    map_d[i] = '{valid: 1'b1, label: wr_label};
                end else begin
                    map_d[i] = map_q[i];
                end
            end
        end else begin
            map_d = map_q;
        end
    end

    // Indexed read of map[g] and parallel compare of d against every bound label.
    always_comb begin
        rd_valid = 1'b0;
        rd_label = {LBL_W{1'b0}};
        cam_hit  = 1'b0;
        for (int i = 0; i < MAX_OBJ; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_valid = map_q[i].valid;
                rd_label = map_q[i].label;
            end else begin
                rd_valid = rd_valid;
            end
            if (map_q[i].valid && (map_q[i].label == cam_label)) begin
                cam_hit = 1'b1;
            end else begin
                cam_hit = cam_hit;
            end
        end
    end

    // Table storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OBJ; i++) begin
                map_q[i] <= '0;
            end
        end else begin
            map_q <= map_d;
        end
    end

endmodule

// File: rtl/cle_label_checker.sv
// Scans the CLE result SRAM against a golden object map, accepting any label
// permutation, and reports error count, bound-object count and pass/fail.
module cle_label_checker #(
    parameter int IMG_W   = cle_chk_pkg::IMG_W,
    parameter int IMG_H   = cle_chk_pkg::IMG_H,
    parameter int LBL_W   = cle_chk_pkg::LBL_W,
    parameter int MAX_OBJ = cle_chk_pkg::MAX_OBJ,
    parameter int ADDR_W  = $clog2(IMG_W * IMG_H),
    parameter int OBJ_W   = $clog2(MAX_OBJ + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] dut_a,
    input  logic [LBL_W-1:0]  dut_q,
    output logic [ADDR_W-1:0] gold_a,
    input  logic [LBL_W-1:0]  gold_q,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [OBJ_W-1:0]  obj_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    import cle_chk_pkg::*;

    localparam int                NPIX        = IMG_W * IMG_H;
    localparam int                IDX_W       = map_idx_width(MAX_OBJ);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] NO_ERR_ADDR = {ADDR_W{1'b1}};
    localparam logic [LBL_W-1:0]  MAX_ID      = LBL_W'(MAX_OBJ);

    chk_state_t        state_q, state_d;
    logic [ADDR_W-1:0] dut_a_q, dut_a_d;
    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic [OBJ_W-1:0]  obj_cnt_q, obj_cnt_d;
    logic [ADDR_W-1:0] first_err_q, first_err_d;

    logic              map_clr_s;
    logic [IDX_W-1:0]  map_idx_s;
    logic              map_rd_valid_s;
    logic [LBL_W-1:0]  map_rd_label_s;
    logic              cam_hit_s;
    logic              pix_err_s;
    logic              bind_s;

    // Object IDs 1..MAX_OBJ occupy table slots 0..MAX_OBJ-1.
    assign map_idx_s = IDX_W'(gold_q - LBL_W'(1));

    cle_label_map #(
        .LBL_W   (LBL_W),
        .MAX_OBJ (MAX_OBJ),
        .IDX_W   (IDX_W)
    ) u_map (
        .clk       (clk),
        .rst_n     (reset),
        .clr       (map_clr_s),
        .rd_idx    (map_idx_s),
        .rd_valid  (map_rd_valid_s),
        .rd_label  (map_rd_label_s),
        .cam_label (dut_q),
        .cam_hit   (cam_hit_s),
        .wr_en     (bind_s),
        .wr_idx    (map_idx_s),
        .wr_label  (dut_q)
    );

    // Stage-1 pixel verdict; a failed bind leaves the object unbound for a retry.
    always_comb begin
        pix_err_s = 1'b0;
        bind_s    = 1'b0;
        if (s1_valid_q) begin
            if (gold_q == {LBL_W{1'b0}}) begin
                pix_err_s = (dut_q != {LBL_W{1'b0}});
            end else if (gold_q > MAX_ID) begin
                pix_err_s = 1'b1;
            end else if (!map_rd_valid_s) begin
                if ((dut_q == {LBL_W{1'b0}}) || cam_hit_s) begin
                    pix_err_s = 1'b1;
                end else begin
                    bind_s = 1'b1;
                end
            end else begin
                pix_err_s = (dut_q != map_rd_label_s);
            end
        end else begin
            pix_err_s = 1'b0;
            bind_s    = 1'b0;
        end
    end

    // FSM next state, address counter, stage-1 capture and result counters.
    always_comb begin
        state_d     = state_q;
        dut_a_d     = dut_a_q;
        s1_valid_d  = (state_q == SCAN);
        s1_addr_d   = dut_a_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q + {{ADDR_W{1'b0}}, pix_err_s};
        obj_cnt_d   = obj_cnt_q + {{(OBJ_W-1){1'b0}}, bind_s};
        map_clr_s   = 1'b0;
        if (pix_err_s && (err_cnt_q == {(ADDR_W+1){1'b0}})) begin
            first_err_d = s1_addr_q;
        end else begin
            first_err_d = first_err_q;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SCAN;
                    dut_a_d     = {ADDR_W{1'b0}};
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    err_cnt_d   = {(ADDR_W+1){1'b0}};
                    obj_cnt_d   = {OBJ_W{1'b0}};
                    first_err_d = NO_ERR_ADDR;
                    map_clr_s   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (dut_a_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    dut_a_d = dut_a_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_cnt_q == {(ADDR_W+1){1'b0}});
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dut_a_q     <= {ADDR_W{1'b0}};
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= {ADDR_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= {(ADDR_W+1){1'b0}};
            obj_cnt_q   <= {OBJ_W{1'b0}};
            first_err_q <= NO_ERR_ADDR;
        end else begin
            state_q     <= state_d;
            dut_a_q     <= dut_a_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            obj_cnt_q   <= obj_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    assign dut_a          = dut_a_q;
    assign gold_a         = dut_a_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign obj_cnt        = obj_cnt_q;
    assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_cle_label_checker.sv
// Scoreboard bench: each scan pushes its expected report; a monitor checks it on done.
module tb_cle_label_checker;

    import cle_chk_pkg::*;

    localparam int NP     = IMG_W * IMG_H;
    localparam int AW     = $clog2(NP);
    localparam int OW     = $clog2(MAX_OBJ + 1);
    localparam int NO_ERR = (1 << AW) - 1;

    logic             clk    = 1'b0;
    logic             reset  = 1'b0;
    logic             start  = 1'b0;
    logic [AW-1:0]    dut_a, gold_a;
    logic [LBL_W-1:0] dut_q  = '0;
    logic [LBL_W-1:0] gold_q = '0;
    logic             busy, done, pass;
    logic [AW:0]      err_cnt;
    logic [OW-1:0]    obj_cnt;
    logic [AW-1:0]    first_err_addr;

    logic [LBL_W-1:0] dut_mem  [NP];
    logic [LBL_W-1:0] gold_mem [NP];

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    typedef struct {
        int     err;
        int     obj;
        int     first;
        bit     pass;
        longint due;
    } exp_t;

    exp_t expq[$];

    cle_label_checker dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .dut_a          (dut_a),
        .dut_q          (dut_q),
        .gold_a         (gold_a),
        .gold_q         (gold_q),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .obj_cnt        (obj_cnt),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        dut_q  <= dut_mem[dut_a];
        gold_q <= gold_mem[gold_a];
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && done) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = expq.pop_front();
                check("done_cycle", cyc, e.due);
                check("err_cnt", err_cnt, e.err);
                check("obj_cnt", obj_cnt, e.obj);
                check("first_err_addr", first_err_addr, e.first);
                check("pass", pass, e.pass);
                check("busy_at_done", busy, 0);
            end
        end
    end

    // Reference: walk the image in address order applying the labeling rules.
    function automatic exp_t model();
        exp_t e;
        int   map_l [MAX_OBJ+1];
        bit   map_v [MAX_OBJ+1];
        bit   owned [1 << LBL_W];
        int   g, d;
        bit   bad;
        e = '{err: 0, obj: 0, first: NO_ERR, pass: 1'b0, due: 0};
        for (int i = 0; i <= MAX_OBJ; i++) begin
            map_v[i] = 1'b0;
            map_l[i] = 0;
        end
        for (int i = 0; i < (1 << LBL_W); i++) owned[i] = 1'b0;
        for (int a = 0; a < NP; a++) begin
            g   = int'(gold_mem[a]);
            d   = int'(dut_mem[a]);
            bad = 1'b0;
            if (g == 0) bad = (d != 0);
            else if (g > MAX_OBJ) bad = 1'b1;
            else if (map_v[g]) bad = (d != map_l[g]);
            else if (d == 0 || owned[d]) bad = 1'b1;
            else begin
                map_v[g] = 1'b1;
                map_l[g] = d;
                owned[d] = 1'b1;
                e.obj++;
            end
            if (bad) begin
                if (e.err == 0) e.first = a;
                e.err++;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic clear_imgs();
        for (int a = 0; a < NP; a++) begin
            dut_mem[a]  = '0;
            gold_mem[a] = '0;
        end
    endtask

    task automatic paint(input int id, input int lbl, input int y0, input int y1,
                         input int x0, input int x1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                gold_mem[y*IMG_W + x] = LBL_W'(id);
                dut_mem[y*IMG_W + x]  = LBL_W'(lbl);
            end
        end
    endtask

    task automatic three_objects();
        clear_imgs();
        paint(1, 8'h07, 2, 4, 3, 6);
        paint(2, 8'h02, 10, 12, 10, 20);
        paint(3, 8'h40, 25, 28, 0, 31);
    endtask

    task automatic gen_random();
        bit id_used  [64];
        bit lbl_used [256];
        int id, lbl, y0, y1, x0, x1, nc, a;
        clear_imgs();
        for (int i = 0; i < 64; i++) id_used[i] = 1'b0;
        for (int i = 0; i < 256; i++) lbl_used[i] = 1'b0;
        for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
            if ($urandom_range(0, 7) == 0) id = int'($urandom_range(MAX_OBJ + 8, MAX_OBJ + 1));
            else id = int'($urandom_range(MAX_OBJ, 1));
            if (!id_used[id]) begin
                id_used[id] = 1'b1;
                do lbl = int'($urandom_range(255, 1)); while (lbl_used[lbl]);
                lbl_used[lbl] = 1'b1;
                y0 = int'($urandom_range(IMG_H - 1, 0));
                y1 = (y0 + int'($urandom_range(6, 0)) < IMG_H) ? y0 + int'($urandom_range(6, 0)) : IMG_H - 1;
                x0 = int'($urandom_range(IMG_W - 1, 0));
                x1 = (x0 + int'($urandom_range(8, 0)) < IMG_W) ? x0 + int'($urandom_range(8, 0)) : IMG_W - 1;
                paint(id, lbl, y0, y1, x0, x1);
            end
        end
        nc = int'($urandom_range(4, 0));
        for (int c = 0; c < nc; c++) begin
            a = int'($urandom_range(NP - 1, 0));
            dut_mem[a] = LBL_W'($urandom_range(255, 0));
        end
    endtask

    task automatic run_scan(input exp_t e);
        @(negedge clk);
        start = 1'b1;
        e.due = cyc + NP + 3;
        expq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < NP + 50 && expq.size() != 0; i++) @(negedge clk);
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=pending required=done");
            expq.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_obj_cnt"}, obj_cnt, 0);
        check({tag, "_dut_a"}, dut_a, 0);
        check({tag, "_first_err_addr"}, first_err_addr, NO_ERR);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit seen;
        clear_imgs();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_scan('{err: 0, obj: 0, first: NO_ERR, pass: 1'b1, due: 0});
        wait_idle();

        three_objects();
        run_scan('{err: 0, obj: 3, first: NO_ERR, pass: 1'b1, due: 0});
        wait_idle();
        check("hold_pass_idle", pass, 1);
        check("hold_obj_cnt_idle", obj_cnt, 3);

        clear_imgs();
        paint(1, 8'h05, 0, 0, 10, 14);
        paint(2, 8'h05, 3, 3, 4, 7);
        run_scan('{err: 4, obj: 1, first: 100, pass: 1'b0, due: 0});
        wait_idle();

        clear_imgs();
        paint(1, 8'h01, 6, 6, 8, 13);
        for (int a = 203; a <= 205; a++) dut_mem[a] = 8'h02;
        run_scan('{err: 3, obj: 1, first: 203, pass: 1'b0, due: 0});
        wait_idle();

        three_objects();
        dut_mem[17] = 8'h09;
        run_scan('{err: 1, obj: 3, first: 17, pass: 1'b0, due: 0});
        wait_idle();

        // A start pulse in the middle of a scan must not restart it.
        three_objects();
        run_scan('{err: 0, obj: 3, first: NO_ERR, pass: 1'b1, due: 0});
        repeat (300) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Abort at address 500 with a two-cycle reset, then rescan.
        three_objects();
        dut_mem[40] = 8'h33;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < NP && !seen; i++) begin
            @(negedge clk);
            if (dut_a == AW'(500)) seen = 1'b1;
        end
        check("abort_addr_reached", seen, 1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        @(negedge clk);
        reset = 1'b1;
        dut_mem[40] = 8'h00;
        run_scan('{err: 0, obj: 3, first: NO_ERR, pass: 1'b1, due: 0});
        wait_idle();

        for (int r = 0; r < 8; r++) begin
            gen_random();
            run_scan(model());
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cle_label_checker.md
Name: cle_label_checker

Overview:
- Synthesisable, parametrised checker for connected-component labeling results.
- Scans the CLE result SRAM against a golden object map and tolerates any label permutation.
- Flags the following as errors: background mismatches, label splits within one object, and label sharing between objects.
- Sits beside the CLE in the on-chip test wrapper; reports error count, bound-object count and pass/fail.

Parameters:
- IMG_W, 32, image width in pixels
- IMG_H, 32, image height in pixels
- LBL_W, 8, label width of both result and golden data
- MAX_OBJ, 32, maximum golden object ID supported (IDs 1..MAX_OBJ)
- ADDR_W, clog2(IMG_W*IMG_H), derived; do not override

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a scan when idle
- dut_a  out  ADDR_W  result SRAM read address
- dut_q  in  LBL_W  result SRAM data, valid 1 cycle after dut_a
- gold_a  out  ADDR_W  golden memory read address (always equals dut_a)
- gold_q  in  LBL_W  golden data, valid 1 cycle after gold_a; 0 = background
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of scan
- pass  out  1  valid while done/after; 1 iff err_cnt==0
- err_cnt  out  ADDR_W+1  number of erroneous pixels
- obj_cnt  out  clog2(MAX_OBJ+1)  number of golden objects bound to a DUT label
- first_err_addr  out  ADDR_W  address of first erroneous pixel; all-ones if none

Behaviour:
- Reset (reset==0, async):
  - outputs: busy=0, done=0, pass=0, err_cnt=0, obj_cnt=0, dut_a=0, first_err_addr=all-ones.
  - all map entries invalid.
  - FSM returns to IDLE.
- Reset asserted mid-scan aborts the scan; no done pulse.
- FSM states: IDLE -> SCAN -> DRAIN -> FIN -> IDLE.
- IDLE:
  - start=1: clear err_cnt, obj_cnt and all map valid bits; set first_err_addr=all-ones, pass=0, dut_a=0; go to SCAN.
  - start while not IDLE is ignored.
- SCAN:
  - issues one address per cycle, 0..N-1 (N=IMG_W*IMG_H).
  - after N-1 is issued, go to DRAIN.
- DRAIN: one cycle to evaluate the last returned pixel.
- FIN: done=1 for one cycle, pass=(err_cnt==0); then IDLE.
- Latency: start to done = N+3 cycles.
- Pipeline:
  - stage 0: address issue.
  - stage 1: evaluate the returned (g=gold_q, d=dut_q) pair, with a registered valid and address.
  - Map writes made in cycle k are visible to the evaluation in cycle k+1. No hazard, no stall.
- Per-pixel rule, evaluated at stage 1:
  - g==0: error iff d!=0.
  - g>MAX_OBJ: error (out-of-range golden).
  - g in 1..MAX_OBJ, map[g] invalid:
    - d==0 -> error.
    - else if d equals the label of any valid entry -> error; the label is already owned by another object.
    - else bind map[g]=d, set valid, obj_cnt+=1; no error.
  - An object that fails binding stays unbound; its next pixel retries binding.
  - g in 1..MAX_OBJ, map[g] valid: error iff d!=map[g].
- Error handling:
  - every error increments err_cnt by 1.
  - err_cnt cannot overflow: its width holds N.
  - first_err_addr is captured only on the first error of the scan.
- Unknown (X) data is not handled in RTL; the bench must drive known values.
- Outputs hold their final values in IDLE until the next start or reset.

Decomposition:
- Package cle_chk_pkg:
  - constants IMG_W, IMG_H, LBL_W, MAX_OBJ, derived N and ADDR_W.
  - FSM state enum {IDLE, SCAN, DRAIN, FIN}.
  - typedef for the map entry {valid, label}.
- Sub-module cle_label_map:
  - MAX_OBJ-entry register table with indexed read of map[g].
  - parallel compare of d against all valid labels (CAM hit).
  - bind write port and synchronous clear-all.
- Top-level cle_label_checker contains the FSM, address counter, stage-1 registers and counters.

Test Plan:
- Golden all-zero, DUT all-zero -> done at cycle N+3 after start, pass=1, err_cnt=0, obj_cnt=0, first_err_addr=1023.
- Golden with objects 1,2,3; DUT uses labels 0x07, 0x02, 0x40 consistently -> pass=1, err_cnt=0, obj_cnt=3.
- Golden object 1 (5 px) and object 2 (4 px); DUT labels both 0x05 -> object 2 pixels all error: err_cnt=4, obj_cnt=1, first_err_addr = first pixel of object 2.
- Golden object 1 (6 px); DUT labels first 3 px 0x01 and last 3 px 0x02 -> err_cnt=3, first_err_addr = 4th pixel.
- DUT writes 0x09 at background address 17; golden 0 there; otherwise correct -> err_cnt=1, first_err_addr=17, pass=0.
- Assert reset for 2 cycles at scan address 500, then start again with a correct image -> no done during abort, all outputs at reset values, second scan pass=1; also a start pulse mid-scan is ignored (done occurs at the original N+3).
